// File: rtl/stream_skid_fifo.sv
// Registered stream buffer: DEPTH-entry circular FIFO carrying {last, data}.
// Latency: 1 cycle minimum from push to o_valid, no same-cycle bypass.
// Backpressure: o_ready/o_valid are flops computed from the next count, so there is no combinational path from i_valid/i_ready.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_flush             synchronous clear of all buffered words (push/pop in that cycle dropped)
//   i_data/i_last/i_valid/o_ready   upstream side
//   o_data/o_last/o_valid/i_ready   downstream side (head entry)
//   o_level             number of words held, 0..DEPTH
module stream_skid_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [LVL_W-1:0]  o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    // Entry layout: bit DATA_W is the packet-end flag, low bits are data.
    logic [DATA_W:0]    mem_q [DEPTH];
    logic [DATA_W:0]    mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               rdy_q, rdy_d;
    logic               vld_q, vld_d;

    logic               push;
    logic               pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdy_d    = rdy_q;
        vld_d    = vld_q;

        push = i_valid && rdy_q;
        pop  = vld_q && i_ready;

        if (i_flush) begin
            // Flush wins over any handshake in the same cycle; the stored
            // words are left in place but become unreachable.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rdy_d    = 1'b1;
            vld_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {i_last, i_data};
                // Explicit wrap so non-power-of-two depths work.
                wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + LVL_W'(push) - LVL_W'(pop);
            // Handshakes are registered from the next count so both sides
            // see flop outputs only.
            rdy_d   = (count_d < LVL_MAX);
            vld_d   = (count_d != '0);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
        end
    end

    assign o_ready = rdy_q;
    assign o_valid = vld_q;
    assign o_level = count_q;
    assign o_data  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign o_last  = mem_q[rd_ptr_q][DATA_W];

endmodule

// File: tb/tb_stream_skid_fifo.sv
module tb_stream_skid_fifo;

    // Three instances: [0] DEPTH=2, [1] DEPTH=4, [2] DEPTH=3.
    logic       clk;
    logic       rst;
    logic       vin  [3];
    logic [7:0] din  [3];
    logic       lin  [3];
    logic       rin  [3];
    logic       fl   [3];
    logic       ordy [3];
    logic       ovld [3];
    logic [7:0] odat [3];
    logic       olst [3];
    logic [2:0] lvl  [3];

    logic [1:0] lvl0;
    logic [2:0] lvl1;
    logic [1:0] lvl2;

    int n_cmp;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_skid_fifo #(.DATA_W(8), .DEPTH(2)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_flush(fl[0]),
        .i_data(din[0]), .i_last(lin[0]), .i_valid(vin[0]), .o_ready(ordy[0]),
        .o_data(odat[0]), .o_last(olst[0]), .o_valid(ovld[0]), .i_ready(rin[0]),
        .o_level(lvl0)
    );

    stream_skid_fifo #(.DATA_W(8), .DEPTH(4)) u_d4 (
        .i_clk(clk), .i_rst(rst), .i_flush(fl[1]),
        .i_data(din[1]), .i_last(lin[1]), .i_valid(vin[1]), .o_ready(ordy[1]),
        .o_data(odat[1]), .o_last(olst[1]), .o_valid(ovld[1]), .i_ready(rin[1]),
        .o_level(lvl1)
    );

    stream_skid_fifo #(.DATA_W(8), .DEPTH(3)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_flush(fl[2]),
        .i_data(din[2]), .i_last(lin[2]), .i_valid(vin[2]), .o_ready(ordy[2]),
        .o_data(odat[2]), .o_last(olst[2]), .o_valid(ovld[2]), .i_ready(rin[2]),
        .o_level(lvl2)
    );

    assign lvl[0] = {1'b0, lvl0};
    assign lvl[1] = lvl1;
    assign lvl[2] = {1'b0, lvl2};

    typedef struct {
        int         inst;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        logic       f;
        logic       e_rdy;
        logic       e_vld;
        logic       chk_d;
        logic [7:0] e_d;
        logic       e_l;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int inst, logic v, logic [7:0] d, logic l, logic r, logic f,
                                logic e_rdy, logic e_vld, logic chk_d, logic [7:0] e_d,
                                logic e_l, logic [2:0] e_lvl);
        vec_t t;
        t.inst = inst; t.v = v; t.d = d; t.l = l; t.r = r; t.f = f;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.chk_d = chk_d; t.e_d = e_d;
        t.e_l = e_l; t.e_lvl = e_lvl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0; din[i] = 8'h00; lin[i] = 1'b0; rin[i] = 1'b0; fl[i] = 1'b0;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle_all();
        rst = 1'b1;

        // ---------------- reset state ----------------
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready[%0d]", i), 32'(ordy[i]), 0);
            chk($sformatf("rst_valid[%0d]", i), 32'(ovld[i]), 0);
            chk($sformatf("rst_level[%0d]", i), 32'(lvl[i]), 0);
            chk($sformatf("rst_data[%0d]", i), 32'(odat[i]), 0);
            chk($sformatf("rst_last[%0d]", i), 32'(olst[i]), 0);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idle_ready[%0d]", i), 32'(ordy[i]), 1);
                chk($sformatf("idle_valid[%0d]", i), 32'(ovld[i]), 0);
                chk($sformatf("idle_level[%0d]", i), 32'(lvl[i]), 0);
            end
        end

        // ---------------- table-driven vectors ----------------
        // inst, v, d, l, r, f  |  e_rdy, e_vld, chk_d, e_d, e_l, e_lvl (after the edge)
        // DEPTH=2: fill with downstream stalled, 0x33 held off, then drain.
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 0,   1, 1, 1, 8'h11, 0, 3'd1));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0,   0, 1, 1, 8'h11, 0, 3'd2));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0,   0, 1, 1, 8'h11, 0, 3'd2));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0,   0, 1, 1, 8'h11, 0, 3'd2));
        tbl.push_back(mk(0, 1, 8'h33, 0, 1, 0,   1, 1, 1, 8'h22, 0, 3'd1));
        tbl.push_back(mk(0, 1, 8'h33, 0, 1, 0,   1, 1, 1, 8'h33, 0, 3'd1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0,   1, 0, 0, 8'h00, 0, 3'd0));
        // DEPTH=4: last flag travels only with 0xA5.
        tbl.push_back(mk(1, 1, 8'h01, 0, 1, 0,   1, 1, 1, 8'h01, 0, 3'd1));
        tbl.push_back(mk(1, 1, 8'hA5, 1, 1, 0,   1, 1, 1, 8'hA5, 1, 3'd1));
        tbl.push_back(mk(1, 1, 8'h02, 0, 1, 0,   1, 1, 1, 8'h02, 0, 3'd1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1, 0, 0, 8'h00, 0, 3'd0));
        // DEPTH=4: fill to 2, flush together with push of 0x77 and a pop attempt.
        tbl.push_back(mk(1, 1, 8'h55, 0, 0, 0,   1, 1, 1, 8'h55, 0, 3'd1));
        tbl.push_back(mk(1, 1, 8'h66, 0, 0, 0,   1, 1, 1, 8'h55, 0, 3'd2));
        tbl.push_back(mk(1, 1, 8'h77, 0, 1, 1,   1, 0, 0, 8'h00, 0, 3'd0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1, 0, 0, 8'h00, 0, 3'd0));
        tbl.push_back(mk(1, 1, 8'h88, 0, 0, 0,   1, 1, 1, 8'h88, 0, 3'd1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1, 0, 0, 8'h00, 0, 3'd0));

        foreach (tbl[k]) begin
            int n;
            idle_all();
            n = tbl[k].inst;
            vin[n] = tbl[k].v; din[n] = tbl[k].d; lin[n] = tbl[k].l;
            rin[n] = tbl[k].r; fl[n]  = tbl[k].f;
            step();
            chk($sformatf("vec%0d_ready", k), 32'(ordy[n]), 32'(tbl[k].e_rdy));
            chk($sformatf("vec%0d_valid", k), 32'(ovld[n]), 32'(tbl[k].e_vld));
            chk($sformatf("vec%0d_level", k), 32'(lvl[n]), 32'(tbl[k].e_lvl));
            if (tbl[k].chk_d) begin
                chk($sformatf("vec%0d_data", k), 32'(odat[n]), 32'(tbl[k].e_d));
                chk($sformatf("vec%0d_last", k), 32'(olst[n]), 32'(tbl[k].e_l));
            end
        end
        idle_all();

        // ---------------- DEPTH=4 continuous stream ----------------
        rin[1] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("cont_ready_before_%0d", i), 32'(ordy[1]), 1);
            vin[1] = 1'b1;
            din[1] = 8'(i);
            step();
            chk($sformatf("cont_valid_%0d", i), 32'(ovld[1]), 1);
            chk($sformatf("cont_data_%0d", i), 32'(odat[1]), 32'(i));
            chk($sformatf("cont_level_%0d", i), 32'(lvl[1]), 1);
        end
        vin[1] = 1'b0;
        step();
        chk("cont_drain_valid", 32'(ovld[1]), 0);
        chk("cont_drain_level", 32'(lvl[1]), 0);
        idle_all();

        // ---------------- DEPTH=3 random traffic with scoreboard ----------------
        begin
            logic [8:0] q[$];
            logic [8:0] w;
            logic       pend;
            logic       do_push;
            logic       do_pop;
            int         acc;
            int         cyc;
            pend = 1'b0;
            w    = '0;
            acc  = 0;
            cyc  = 0;
            while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
                if (!pend && acc < 1000 && $urandom_range(0, 3) != 0) begin
                    pend = 1'b1;
                    w    = 9'($urandom_range(0, 511));
                end
                vin[2] = pend;
                din[2] = w[7:0];
                lin[2] = w[8];
                rin[2] = ($urandom_range(0, 3) != 0);
                do_push = pend && ordy[2];
                do_pop  = ovld[2] && rin[2];
                if (do_pop) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rand_underflow: valid=1 with model empty at t=%0t", $time);
                    end else begin
                        chk("rand_word", 32'({olst[2], odat[2]}), 32'(q.pop_front()));
                    end
                end
                if (do_push) begin
                    n_cmp++;
                    if (lvl[2] == 3'd3) begin
                        n_fail++;
                        $display("FAIL rand_push_when_full: level=%0d required <3", lvl[2]);
                    end
                    q.push_back(w);
                    pend = 1'b0;
                    acc++;
                end
                step();
                cyc++;
                chk("rand_level", 32'(lvl[2]), 32'(q.size()));
                chk("rand_valid", 32'(ovld[2]), 32'(q.size() != 0));
                chk("rand_ready", 32'(ordy[2]), 32'(q.size() < 3));
            end
            n_cmp++;
            if (cyc >= 20000) begin
                n_fail++;
                $display("FAIL rand_timeout: accepted %0d words, required 1000", acc);
            end
        end
        idle_all();

        // ---------------- asynchronous reset mid-operation ----------------
        vin[1] = 1'b1;
        din[1] = 8'h99;
        step();
        vin[1] = 1'b0;
        chk("mid_valid_before", 32'(ovld[1]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ovld[1]), 0);
        chk("mid_rst_ready", 32'(ordy[1]), 0);
        chk("mid_rst_level", 32'(lvl[1]), 0);
        chk("mid_rst_data", 32'(odat[1]), 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_post_ready", 32'(ordy[1]), 1);
        chk("mid_post_valid", 32'(ovld[1]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_skid_fifo.md
Name: stream_skid_fifo

Overview:
Parametrised registered buffer for the data+valid+ready stream protocol. It is the general form of the single-word stream buffer: configurable data width, configurable depth, a packet-end flag, an occupancy output and a synchronous flush. Both o_ready and o_valid come directly from flops, so the block breaks timing paths between slow upstream and downstream logic in either direction. It is placed between the FT245/USB byte streams and the register/sample pipelines, and between clock-domain-local processing stages.

Parameters:
DATA_W, 8, width of i_data/o_data in bits; minimum 1.
DEPTH, 2, number of storage entries; legal range 2..16, need not be a power of two.
LVL_W, $clog2(DEPTH+1), width of o_level; derived, not to be overridden.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_flush  in  1  synchronous clear of all buffered words
i_data  in  DATA_W  upstream data
i_last  in  1  upstream end-of-packet flag, stored alongside data
i_valid  in  1  upstream valid
o_ready  out  1  upstream ready (flop output)
o_data  out  DATA_W  downstream data (head entry)
o_last  out  1  downstream end-of-packet flag (head entry)
o_valid  out  1  downstream valid (flop output)
i_ready  in  1  downstream ready
o_level  out  LVL_W  number of words held, 0..DEPTH

Behaviour:
- Reset is asynchronous, active-high, on i_clk / i_rst.
  - During reset: o_ready=0, o_valid=0, o_level=0, o_data=0, o_last=0. Storage, pointers and count are cleared.
  - First rising edge after reset release: o_ready goes to 1. Reset asserted mid-operation discards all contents at once.
- Transfers:
  - Push = i_valid && o_ready.
  - Pop = o_valid && i_ready.
  - Both are evaluated on the same edge.
- Storage is a circular buffer with write and read pointers.
  - Each pointer wraps from DEPTH-1 to 0; explicit compare, no reliance on power-of-two overflow.
  - {i_last, i_data} is written at wr_ptr on push. The read pointer advances on pop.
- o_data and o_last are the entry at rd_ptr. Their value is don't-care when o_valid=0, except after reset, where they are 0.
- Count update:
  - next_count = count + push - pop.
  - o_level is the count register itself.
- Registered handshakes:
  - o_ready <= (next_count < DEPTH).
  - o_valid <= (next_count != 0).
  - Neither output depends combinationally on i_valid or i_ready.
- Latency:
  - A word pushed into an empty buffer on edge N appears with o_valid=1 after edge N.
  - There is no same-cycle bypass; minimum latency is 1 cycle.
- Throughput:
  - With DEPTH>=2 and the downstream always ready, sustained 1 word/cycle.
  - With push and pop on the same edge, count is unchanged and o_ready stays 1 if it was 1.
- Full: when count==DEPTH, o_ready=0 and no push is possible. A pop on that edge makes o_ready=1 on the next cycle.
- Empty: when count==0, o_valid=0 and no pop is possible. A push on that edge makes o_valid=1 on the next cycle.
- Overflow and underflow are structurally impossible. A bench assertion checks that push never occurs with count==DEPTH.
- i_flush (synchronous, highest priority after reset):
  - On an edge with i_flush=1, pointers and count go to 0, o_valid goes to 0 and o_ready goes to 1.
  - Any push or pop in that same cycle is ignored: the word is not stored and the pop is not counted.
  - Upstream must treat a handshake that completes during flush as dropped.
- i_last has no control effect; it only travels with its data word.
- Stream rules:
  - Upstream may not retract i_valid or change i_data/i_last while i_valid=1 && o_ready=0.
  - This block honours the same rule downstream: the head entry is stable while o_valid=1 && i_ready=0.

Test Plan:
- Reset, then idle 3 cycles -> o_ready 0 during reset and 1 from the first cycle after; o_valid=0 and o_level=0 throughout.
- DEPTH=2, DATA_W=8; push 0x11, 0x22, 0x33 back-to-back with i_ready=0 -> 0x11 and 0x22 accepted, o_ready=0 after the second push, o_level=2, o_data=0x11 held stable; then i_ready=1 -> 0x11, 0x22, 0x33 emerge in order and o_level returns to 0.
- DEPTH=4; continuous push of 0x00..0xFF with i_ready=1 -> one word per cycle after the first-cycle latency, o_level stays at 1, order preserved, no gaps.
- DEPTH=3 (non-power-of-two); random i_valid/i_ready, 1000 words -> scoreboard matches, pointers wrap 2->0 correctly, o_level is never above 3, and no push occurs when full.
- Push 0xA5 with i_last=1 between 0x01 and 0x02 -> o_last=1 only while o_data=0xA5.
- Fill to level 2 (DEPTH=4), then assert i_flush together with a push of 0x77 -> next cycle o_level=0, o_valid=0, o_ready=1, and 0x77 never emerges.
